// File: rtl/tl45_register_read.sv
`default_nettype none
// ============================================================================
// Module   : tl45_register_read
// Purpose  : Register-read / operand-forward stage. Owns the 16x32 register file,
//            forwards from ALU/MEM/WB, inserts a bubble on load-use hazards.
// Revision : 1.0 - initial release
// ============================================================================
module tl45_register_read #(
    parameter logic [4:0] OP_LOAD  = 5'h14,
    parameter int         NUM_REGS = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    output logic        o_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_flush,
    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [3:0]  i_sr1,
    input  logic [3:0]  i_sr2,
    input  logic [3:0]  i_jmp_cond,
    input  logic        i_imm_valid,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_fwd_alu_reg,
    input  logic [31:0] i_fwd_alu_val,
    input  logic [3:0]  i_fwd_mem_reg,
    input  logic [31:0] i_fwd_mem_val,
    input  logic [3:0]  i_wb_reg,
    input  logic [31:0] i_wb_val,
    output logic [4:0]  o_opcode,
    output logic [3:0]  o_dr,
    output logic [3:0]  o_jmp_cond,
    output logic [31:0] o_sr1_val,
    output logic [31:0] o_sr2_val,
    output logic [31:0] o_target_offset,
    output logic [31:0] o_pc
);

    logic [31:0] r_regs [NUM_REGS];

    logic [4:0]  r_opcode;
    logic [3:0]  r_dr;
    logic [3:0]  r_jmp_cond;
    logic [31:0] r_sr1_val;
    logic [31:0] r_sr2_val;
    logic [31:0] r_target_offset;
    logic [31:0] r_pc;

    logic [31:0] w_sr1_sel;
    logic [31:0] w_sr2_sel;
    logic [31:0] w_sr2_operand;
    logic        w_load_use;

    // Youngest producer wins; WB is a write-through so same-cycle reads see it.
    function automatic logic [31:0] f_select(
        input logic [3:0]  src,
        input logic [3:0]  alu_reg,
        input logic [31:0] alu_val,
        input logic [3:0]  mem_reg,
        input logic [31:0] mem_val,
        input logic [3:0]  wb_reg,
        input logic [31:0] wb_val,
        input logic [31:0] rf_val
    );
        logic [31:0] v;
        if (src == 4'd0)                             v = 32'd0;
        else if (alu_reg != 4'd0 && alu_reg == src)  v = alu_val;
        else if (mem_reg != 4'd0 && mem_reg == src)  v = mem_val;
        else if (wb_reg != 4'd0 && wb_reg == src)    v = wb_val;
        else                                         v = rf_val;
        return v;
    endfunction

    always_comb begin
        w_sr1_sel = f_select(i_sr1, i_fwd_alu_reg, i_fwd_alu_val, i_fwd_mem_reg,
                             i_fwd_mem_val, i_wb_reg, i_wb_val, r_regs[i_sr1]);
        w_sr2_sel = f_select(i_sr2, i_fwd_alu_reg, i_fwd_alu_val, i_fwd_mem_reg,
                             i_fwd_mem_val, i_wb_reg, i_wb_val, r_regs[i_sr2]);
        w_sr2_operand = i_imm_valid ? i_imm : w_sr2_sel;
    end

    // A load's result is only available from MEM, so its consumer waits one cycle.
    always_comb begin
        w_load_use = (i_opcode != 5'd0) && (r_opcode == OP_LOAD) && (r_dr != 4'd0) &&
                     ((r_dr == i_sr1) || (!i_imm_valid && (r_dr == i_sr2)));
    end

    assign o_pipe_stall = i_pipe_stall | w_load_use;
    assign o_pipe_flush = i_pipe_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= 32'd0;
            end
        end else if (i_wb_reg != 4'd0) begin
            r_regs[i_wb_reg] <= i_wb_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_pipe_flush || (!i_pipe_stall && w_load_use)) begin
            r_opcode        <= 5'd0;
            r_dr            <= 4'd0;
            r_jmp_cond      <= 4'd0;
            r_sr1_val       <= 32'd0;
            r_sr2_val       <= 32'd0;
            r_target_offset <= 32'd0;
            r_pc            <= 32'd0;
        end else if (!i_pipe_stall) begin
            r_opcode        <= i_opcode;
            r_dr            <= i_dr;
            r_jmp_cond      <= i_jmp_cond;
            r_sr1_val       <= w_sr1_sel;
            r_sr2_val       <= w_sr2_operand;
            r_target_offset <= i_imm;
            r_pc            <= i_pc;
        end
    end

    assign o_opcode        = r_opcode;
    assign o_dr            = r_dr;
    assign o_jmp_cond      = r_jmp_cond;
    assign o_sr1_val       = r_sr1_val;
    assign o_sr2_val       = r_sr2_val;
    assign o_target_offset = r_target_offset;
    assign o_pc            = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_tl45_register_read.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl45_register_read
// Purpose  : Directed self-checking bench for the register-read stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl45_register_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pipe_stall, o_pipe_stall, i_pipe_flush, o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond;
    logic        i_imm_valid;
    logic [31:0] i_imm, i_pc;
    logic [3:0]  i_fwd_alu_reg, i_fwd_mem_reg, i_wb_reg;
    logic [31:0] i_fwd_alu_val, i_fwd_mem_val, i_wb_val;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr, o_jmp_cond;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    tl45_register_read dut (
        .i_clk(clk), .i_reset(rst),
        .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
        .i_pipe_flush(i_pipe_flush), .o_pipe_flush(o_pipe_flush),
        .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_jmp_cond(i_jmp_cond), .i_imm_valid(i_imm_valid), .i_imm(i_imm), .i_pc(i_pc),
        .i_fwd_alu_reg(i_fwd_alu_reg), .i_fwd_alu_val(i_fwd_alu_val),
        .i_fwd_mem_reg(i_fwd_mem_reg), .i_fwd_mem_val(i_fwd_mem_val),
        .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
        .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
        .o_target_offset(o_target_offset), .o_pc(o_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pipe_stall = 0; i_pipe_flush = 0;
        i_opcode = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_jmp_cond = 0;
        i_imm_valid = 0; i_imm = 0; i_pc = 0;
        i_fwd_alu_reg = 0; i_fwd_alu_val = 0; i_fwd_mem_reg = 0; i_fwd_mem_val = 0;
        i_wb_reg = 0; i_wb_val = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        i_opcode = 5'h1F; i_dr = 4'hA; i_sr1 = 4'h3; i_sr2 = 4'hA; i_jmp_cond = 4'hF;
        i_imm = 32'hCAFEBABE; i_pc = 32'h1234; i_fwd_alu_reg = 4'h3; i_fwd_alu_val = 32'h99;
        i_wb_reg = 4'h3; i_wb_val = 32'hBAD; i_pipe_stall = 1;
        tick(); tick();
        checks++;
        if ({o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc} !== '0)
            $display("FAIL reset_outputs: got op=%h dr=%h sr1=%h sr2=%h off=%h pc=%h, expected all 0",
                     o_opcode, o_dr, o_sr1_val, o_sr2_val, o_target_offset, o_pc);
        else passes++;
        checks++;
        if (o_pipe_stall !== 1'b1) $display("FAIL reset_stall_pass: got %b expected 1", o_pipe_stall);
        else passes++;
        rst = 0;
        clear_inputs();
        i_opcode = 5'h01; i_sr1 = 4'h3; i_sr2 = 4'hA;
        tick();
        checks++;
        if (o_sr1_val !== 32'd0 || o_sr2_val !== 32'd0)
            $display("FAIL reset_regfile: got sr1=%h sr2=%h expected 0/0", o_sr1_val, o_sr2_val);
        else passes++;
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        i_wb_reg = 3; i_wb_val = 32'd1;
        tick();
        i_opcode = 5'h01; i_sr1 = 3;
        i_wb_reg = 3; i_wb_val = 32'd2;
        i_fwd_mem_reg = 3; i_fwd_mem_val = 32'd3;
        i_fwd_alu_reg = 3; i_fwd_alu_val = 32'd4;
        tick();
        checks++;
        if (o_sr1_val !== 32'd4) $display("FAIL prio_alu: got %h expected 4", o_sr1_val);
        else passes++;
        i_fwd_alu_reg = 0;
        tick();
        checks++;
        if (o_sr1_val !== 32'd3) $display("FAIL prio_mem: got %h expected 3", o_sr1_val);
        else passes++;
        i_fwd_mem_reg = 0;
        tick();
        checks++;
        if (o_sr1_val !== 32'd2) $display("FAIL prio_wb: got %h expected 2", o_sr1_val);
        else passes++;
        i_wb_val = 32'h22;
        tick();
        checks++;
        if (o_sr1_val !== 32'h22) $display("FAIL wb_write_through: got %h expected 22", o_sr1_val);
        else passes++;
        i_wb_reg = 0;
        tick();
        checks++;
        if (o_sr1_val !== 32'h22) $display("FAIL regfile_read: got %h expected 22", o_sr1_val);
        else passes++;
        i_sr1 = 0; i_fwd_alu_reg = 0; i_fwd_alu_val = 32'h55;
        i_sr2 = 3; i_fwd_mem_reg = 3; i_fwd_mem_val = 32'h33;
        tick();
        checks++;
        if (o_sr1_val !== 32'd0) $display("FAIL r0_source: got %h expected 0", o_sr1_val);
        else passes++;
        checks++;
        if (o_sr2_val !== 32'h33) $display("FAIL sr2_mem_fwd: got %h expected 33", o_sr2_val);
        else passes++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        i_opcode = 5'h14; i_dr = 5;
        tick();
        i_opcode = 5'h01; i_dr = 6; i_sr1 = 5;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b1) $display("FAIL loaduse_stall: got %b expected 1", o_pipe_stall);
        else passes++;
        tick();
        checks++;
        if (o_opcode !== 5'd0) $display("FAIL loaduse_bubble: got %h expected 0", o_opcode);
        else passes++;
        i_fwd_mem_reg = 5; i_fwd_mem_val = 32'hDEAD;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b0) $display("FAIL loaduse_release: got %b expected 0", o_pipe_stall);
        else passes++;
        tick();
        checks++;
        if (o_sr1_val !== 32'hDEAD || o_opcode !== 5'h01 || o_dr !== 4'd6)
            $display("FAIL loaduse_mem_fwd: got sr1=%h op=%h dr=%h expected DEAD/01/6",
                     o_sr1_val, o_opcode, o_dr);
        else passes++;
        clear_inputs();
        i_opcode = 5'h14; i_dr = 5;
        tick();
        i_opcode = 5'h01; i_sr1 = 1; i_sr2 = 5; i_imm_valid = 1;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b0) $display("FAIL loaduse_imm_sr2: got %b expected 0", o_pipe_stall);
        else passes++;
        i_imm_valid = 0;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b1) $display("FAIL loaduse_sr2: got %b expected 1", o_pipe_stall);
        else passes++;
        i_opcode = 5'h00; i_sr1 = 5;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b0) $display("FAIL loaduse_bubble_decode: got %b expected 0", o_pipe_stall);
        else passes++;
        tick();
    endtask

    task automatic test_stall();
        clear_inputs();
        i_opcode = 5'h02; i_dr = 4; i_sr1 = 3; i_pc = 32'h40;
        tick();
        i_pipe_stall = 1;
        for (int i = 0; i < 4; i++) begin
            i_opcode = 5'(i + 8); i_sr1 = 4'(i); i_pc = 32'(i * 4);
            i_wb_reg = (i == 1) ? 4'd7 : 4'd0; i_wb_val = 32'h77;
            #1;
            checks++;
            if (o_pipe_stall !== 1'b1) $display("FAIL stall_pass[%0d]: got %b expected 1", i, o_pipe_stall);
            else passes++;
            tick();
            checks++;
            if (o_opcode !== 5'h02 || o_sr1_val !== 32'h22 || o_pc !== 32'h40 || o_dr !== 4'd4)
                $display("FAIL stall_hold[%0d]: got op=%h sr1=%h pc=%h dr=%h expected 02/22/40/4",
                         i, o_opcode, o_sr1_val, o_pc, o_dr);
            else passes++;
        end
        clear_inputs();
        i_opcode = 5'h03; i_sr1 = 7;
        tick();
        checks++;
        if (o_sr1_val !== 32'h77 || o_opcode !== 5'h03)
            $display("FAIL stall_wb_r7: got sr1=%h op=%h expected 77/03", o_sr1_val, o_opcode);
        else passes++;
    endtask

    task automatic test_flush();
        clear_inputs();
        i_opcode = 5'h01; i_dr = 9; i_sr1 = 3; i_imm = 32'h5; i_pc = 32'h80; i_jmp_cond = 4'h2;
        i_pipe_flush = 1;
        #1;
        checks++;
        if (o_pipe_flush !== 1'b1) $display("FAIL flush_pass: got %b expected 1", o_pipe_flush);
        else passes++;
        tick();
        checks++;
        if ({o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc} !== '0)
            $display("FAIL flush_bubble: got op=%h dr=%h sr1=%h off=%h pc=%h expected all 0",
                     o_opcode, o_dr, o_sr1_val, o_target_offset, o_pc);
        else passes++;
        clear_inputs();
        i_opcode = 5'h14; i_dr = 5;
        tick();
        i_opcode = 5'h01; i_sr1 = 5; i_pc = 32'h90; i_pipe_flush = 1;
        #1;
        checks++;
        if (o_pipe_stall !== 1'b1) $display("FAIL flush_loaduse_stall: got %b expected 1", o_pipe_stall);
        else passes++;
        tick();
        checks++;
        if (o_opcode !== 5'd0 || o_pc !== 32'd0)
            $display("FAIL flush_loaduse_bubble: got op=%h pc=%h expected 0/0", o_opcode, o_pc);
        else passes++;
    endtask

    task automatic test_immediate();
        clear_inputs();
        i_wb_reg = 2; i_wb_val = 32'h100;
        tick();
        clear_inputs();
        i_opcode = 5'h0C; i_sr1 = 2; i_sr2 = 9; i_imm_valid = 1; i_imm = 32'hFFFFFFF8;
        i_jmp_cond = 4'h3; i_pc = 32'hA0; i_fwd_alu_reg = 9; i_fwd_alu_val = 32'h999;
        tick();
        checks++;
        if (o_sr2_val !== 32'hFFFFFFF8) $display("FAIL imm_sr2: got %h expected FFFFFFF8", o_sr2_val);
        else passes++;
        checks++;
        if (o_target_offset !== 32'hFFFFFFF8)
            $display("FAIL imm_target: got %h expected FFFFFFF8", o_target_offset);
        else passes++;
        checks++;
        if (o_sr1_val !== 32'h100) $display("FAIL imm_sr1: got %h expected 100", o_sr1_val);
        else passes++;
        checks++;
        if (o_jmp_cond !== 4'h3 || o_pc !== 32'hA0 || o_opcode !== 5'h0C)
            $display("FAIL imm_fields: got jc=%h pc=%h op=%h expected 3/A0/0C", o_jmp_cond, o_pc, o_opcode);
        else passes++;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_stall();
        test_flush();
        test_immediate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
